// File: rtl/mul_seq_ctrl.sv
// Radix-2 shift-add multiply sequencer for the ALU MUL/MUL_APX path; holds the pipeline until the product is taken.
// Optional truncated approximate mode is built only when MUL_APX_TRUNC_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start
// BUSY   | one shift-add step per cycle
// DONE   | result valid, waiting for ack
module mul_seq_ctrl #(
  parameter int WIDTH    = 32,
  parameter int APX_SKIP = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             apx,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             ack,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] result
);

  localparam int              CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_EXACT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] load_mcand;
  logic [WIDTH-1:0] load_mplr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    last_count;
  logic             load;
  logic             step;
  logic             finish;

`ifdef MUL_APX_TRUNC_EN
  localparam logic [CW-1:0] LAST_APX = CW'(WIDTH - APX_SKIP - 1);

  logic apx_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      apx_q <= 1'b0;
    end else if (load) begin
      apx_q <= apx;
    end
  end

  // Skipped multiplier bits never contribute, so pre-shift and run fewer steps.
  assign last_count = apx_q ? LAST_APX : LAST_EXACT;
  assign load_mcand = apx ? (op_a << APX_SKIP) : op_a;
  assign load_mplr  = apx ? (op_b >> APX_SKIP) : op_b;
`else
  logic unused_apx;

  assign unused_apx = apx;
  assign last_count = LAST_EXACT;
  assign load_mcand = op_a;
  assign load_mplr  = op_b;
`endif

  assign acc_step = mplr[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    if (flush) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            load     = 1'b1;
            state_nx = S_BUSY;
          end
        end
        S_BUSY: begin
          step = 1'b1;
          if (count == last_count) begin
            finish   = 1'b1;
            state_nx = S_DONE;
          end
        end
        S_DONE: begin
          if (ack) begin
            state_nx = S_IDLE;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy  = (state == S_BUSY);
    done  = (state == S_DONE);
    stall = ((state == S_IDLE) && start && !flush) ||
            (state == S_BUSY) ||
            ((state == S_DONE) && !ack);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplr   <= '0;
      count  <= '0;
      result <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= load_mcand;
      mplr   <= load_mplr;
      count  <= '0;
    end else if (step) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplr   <= mplr >> 1;
      count  <= count + CW'(1);
      // The last partial product is folded in on the same edge that enters DONE.
      if (finish) begin
        result <= acc_step;
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: driver pushes expected products, a negedge monitor pops and checks them.
module tb_mul_seq_ctrl;

  localparam int WIDTH    = 32;
  localparam int APX_SKIP = 8;
`ifdef MUL_APX_TRUNC_EN
  localparam bit APX_EN = 1'b1;
`else
  localparam bit APX_EN = 1'b0;
`endif

  logic             clk;
  logic             reset_n;
  logic             start;
  logic             apx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             ack;
  logic             flush;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] result;

  mul_seq_ctrl #(.WIDTH(WIDTH), .APX_SKIP(APX_SKIP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .apx     (apx),
    .op_a    (op_a),
    .op_b    (op_b),
    .ack     (ack),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .stall   (stall),
    .result  (result)
  );

  typedef struct {
    logic [WIDTH-1:0] res;
    int               e0;
    int               n;
  } exp_t;

  exp_t             sb_q[$];
  exp_t             cur;
  int               total;
  int               bad;
  int               cyc;
  logic             done_prev;
  logic [WIDTH-1:0] prev_result;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic ap);
    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] mask;
    mask = (WIDTH'(1) << APX_SKIP) - WIDTH'(1);
    bb   = (ap && APX_EN) ? (b & ~mask) : b;
    return a * bb;
  endfunction

  function automatic int ref_n(input logic ap);
    return (ap && APX_EN) ? (WIDTH - APX_SKIP) : WIDTH;
  endfunction

  // Monitor: every done rise must match the oldest outstanding expectation.
  initial begin
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          cur = sb_q.pop_front();
          check("result", 64'(result), 64'(cur.res));
          check("latency", 64'(cyc - cur.e0), 64'(cur.n));
        end
      end else if (done) begin
        check("result_hold", 64'(result), 64'(cur.res));
      end
      if (busy) check("stall_busy", 64'(stall), 64'd1);
      if (done && !ack) check("stall_done", 64'(stall), 64'd1);
      if (busy && done) check("busy_done_excl", 64'd1, 64'd0);
      done_prev = done;
    end
  end

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ap,
                        input int ack_dly, input int flush_at, input bit noise, input bit ack_start);
    exp_t e;
    int   w;
    @(posedge clk); #1;
    start = 1'b1; op_a = a; op_b = b; apx = ap;
    e.res = ref_mul(a, b, ap);
    e.e0  = cyc + 1;
    e.n   = ref_n(ap);
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    if (flush_at > 0) begin
      repeat (flush_at - 1) begin
        @(posedge clk); #1;
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      void'(sb_q.pop_back());
      check("flush_busy", 64'(busy), 64'd0);
      check("flush_done", 64'(done), 64'd0);
      check("flush_result", 64'(result), 64'(prev_result));
      return;
    end
    if (noise) begin
      start = 1'b1; op_a = $urandom; op_b = $urandom; apx = 1'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
    end
    w = 0;
    while (!done && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!done) begin
      check("done_timeout", 64'd0, 64'd1);
      void'(sb_q.pop_back());
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      return;
    end
    repeat (ack_dly) begin
      @(posedge clk); #1;
    end
    check("done_held", 64'(done), 64'd1);
    ack = 1'b1;
    if (ack_start) begin
      start = 1'b1; op_a = $urandom; op_b = $urandom;
    end
    @(posedge clk); #1;
    ack = 1'b0;
    start = 1'b0;
    prev_result = e.res;
    check("ack_idle_busy", 64'(busy), 64'd0);
    check("ack_idle_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    check("post_ack_busy", 64'(busy), 64'd0);
    check("post_ack_stall", 64'(stall), 64'd0);
  endtask

  task automatic reset_mid_busy();
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; op_a = 32'd100; op_b = 32'd3; apx = 1'b0;
    e.res = ref_mul(32'd100, 32'd3, 1'b0);
    e.e0  = cyc + 1;
    e.n   = ref_n(1'b0);
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("pre_reset_busy", 64'(busy), 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    void'(sb_q.pop_back());
    prev_result = '0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    #3;
    reset_n = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0; prev_result = '0;
    reset_n = 1'b0; start = 1'b0; apx = 1'b0; op_a = '0; op_b = '0; ack = 1'b0; flush = 1'b0;
    #3;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    #20;
    reset_n = 1'b1;

    run_op(32'd7, 32'd6, 1'b0, 2, 0, 1'b0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5, 0, 1'b0, 1'b0);
    run_op(32'd3, 32'h105, 1'b1, 1, 0, 1'b0, 1'b0);
    run_op(32'd7, 32'd6, 1'b0, 0, 0, 1'b0, 1'b0);
    run_op(32'd5, 32'd5, 1'b0, 0, 10, 1'b0, 1'b0);
    run_op(32'd11, 32'd13, 1'b0, 1, 0, 1'b1, 1'b1);
    reset_mid_busy();
    run_op(32'd9, 32'd9, 1'b0, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             ap;
      int               fa;
      a  = $urandom;
      b  = $urandom;
      ap = 1'($urandom);
      fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, ref_n(ap))) : 0;
      run_op(a, b, ap, int'($urandom_range(0, 3)), fa, 1'($urandom), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
